// File: rtl/frank_sequencer.sv
// FRANK6000 program sequencer: PC, Z/N/C flag register and the IDLE/FETCH/EXEC/HALT control FSM.
// Optional single-step mode (adds i_step) is enabled by defining FRANK_SEQ_SINGLE_STEP_EN.
module frank_sequencer #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_run,
`ifdef FRANK_SEQ_SINGLE_STEP_EN
  input  logic                i_step,
`endif
  output logic                o_mem_req,
  input  logic                i_mem_ready,
  output logic                o_ir_load,
  output logic                o_exec,
  input  logic                i_is_jump,
  input  logic [1:0]          i_jump_cond,
  input  logic [PC_WIDTH-1:0] i_jump_target,
  input  logic                i_halt,
  input  logic [2:0]          i_status,
  input  logic                i_status_we,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [2:0]          o_status,
  output logic                o_jump_taken,
  output logic                o_halted
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic [2:0]          status_reg, status_next;

  logic [3:0] cond_match;
  logic       jump_hit;
  logic       launch;
  logic       exec_continue;

  // Condition code 0 is unconditional; codes 1..3 select flag bits Z, N, C.
  assign cond_match[0] = 1'b1;
  genvar gi;
  generate
    for (gi = 1; gi < 4; gi++) begin : g_cond
      assign cond_match[gi] = status_reg[gi-1];
    end
  endgenerate

  assign jump_hit = i_is_jump & cond_match[i_jump_cond];

`ifdef FRANK_SEQ_SINGLE_STEP_EN
  assign launch        = i_run & i_step;
  assign exec_continue = 1'b0;
`else
  assign launch        = i_run;
  assign exec_continue = i_run;
`endif

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    status_next  = status_reg;
    o_mem_req    = 1'b0;
    o_ir_load    = 1'b0;
    o_exec       = 1'b0;
    o_jump_taken = 1'b0;
    o_halted     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (launch) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        o_mem_req = 1'b1;
        o_ir_load = i_mem_ready;
        if (i_mem_ready) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        o_exec = 1'b1;
        // Jump decision reads status_reg, so a same-cycle flag write only affects later jumps.
        if (i_status_we) status_next = i_status;
        if (i_halt) begin
          state_next = ST_HALT;
        end else begin
          if (jump_hit) begin
            o_jump_taken = 1'b1;
            pc_next      = i_jump_target;
          end else begin
            pc_next = pc_reg + PC_WIDTH'(1);
          end
          state_next = exec_continue ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALT: begin
        o_halted = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg  <= ST_IDLE;
      pc_reg     <= RESET_PC;
      status_reg <= 3'b000;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      status_reg <= status_next;
    end
  end

  assign o_pc     = pc_reg;
  assign o_status = status_reg;

endmodule

// File: tb/tb_frank_sequencer.sv
// Transaction-level bench for frank_sequencer: each instruction is driven as one
// fetch/execute transaction and compared with an arithmetic PC/flag model.
module tb_frank_sequencer;

  logic       clk;
  logic       i_reset;
  logic       i_run;
  logic       i_step;
  logic       o_mem_req;
  logic       i_mem_ready;
  logic       o_ir_load;
  logic       o_exec;
  logic       i_is_jump;
  logic [1:0] i_jump_cond;
  logic [7:0] i_jump_target;
  logic       i_halt;
  logic [2:0] i_status;
  logic       i_status_we;
  logic [7:0] o_pc;
  logic [2:0] o_status;
  logic       o_jump_taken;
  logic       o_halted;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int       m_pc      = 0;
  bit [2:0] m_flags   = 3'b000;
  bit       m_running = 1'b0;

`ifdef FRANK_SEQ_SINGLE_STEP_EN
  localparam bit SINGLE_STEP = 1'b1;
`else
  localparam bit SINGLE_STEP = 1'b0;
`endif

  frank_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_run        (i_run),
`ifdef FRANK_SEQ_SINGLE_STEP_EN
    .i_step       (i_step),
`endif
    .o_mem_req    (o_mem_req),
    .i_mem_ready  (i_mem_ready),
    .o_ir_load    (o_ir_load),
    .o_exec       (o_exec),
    .i_is_jump    (i_is_jump),
    .i_jump_cond  (i_jump_cond),
    .i_jump_target(i_jump_target),
    .i_halt       (i_halt),
    .i_status     (i_status),
    .i_status_we  (i_status_we),
    .o_pc         (o_pc),
    .o_status     (o_status),
    .o_jump_taken (o_jump_taken),
    .o_halted     (o_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_exec_inputs();
    i_is_jump     = 1'b0;
    i_jump_cond   = 2'b00;
    i_jump_target = 8'h00;
    i_halt        = 1'b0;
    i_status      = 3'b000;
    i_status_we   = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    m_pc = 0;
    m_flags = 3'b000;
    m_running = 1'b0;
  endtask

  // Bring the sequencer from IDLE into FETCH if the model says it is parked.
  task automatic launch_if_idle();
    if (!m_running) begin
      i_run  = 1'b1;
      i_step = 1'b1;
      @(negedge clk);
      i_step = 1'b0;
    end
  endtask

  task automatic exec_instr(input int waits, input bit is_jump, input bit [1:0] cond,
                            input bit [7:0] target, input bit we, input bit [2:0] st,
                            input bit run_after);
    bit taken;
    launch_if_idle();
    check("fetch_req", o_mem_req, 1);
    check("fetch_pc", o_pc, m_pc);
    for (int k = 0; k < waits; k++) begin
      i_mem_ready = 1'b0;
      #1;
      check("wait_no_load", o_ir_load, 0);
      @(negedge clk);
      check("wait_req", o_mem_req, 1);
      check("wait_pc", o_pc, m_pc);
      check("wait_no_exec", o_exec, 0);
    end
    i_mem_ready = 1'b1;
    #1;
    check("ir_load", o_ir_load, 1);
    @(negedge clk);
    i_mem_ready = 1'b0;
    check("exec", o_exec, 1);
    check("exec_no_req", o_mem_req, 0);
    i_is_jump     = is_jump;
    i_jump_cond   = cond;
    i_jump_target = target;
    i_status_we   = we;
    i_status      = st;
    i_run         = run_after;
    #1;
    taken = is_jump && (cond == 2'b00 || m_flags[cond - 2'd1] == 1'b1);
    check("jump_taken", o_jump_taken, taken);
    @(negedge clk);
    clear_exec_inputs();
    m_pc = taken ? int'(target) : (m_pc + 1) % 256;
    if (we) m_flags = st;
    m_running = run_after && !SINGLE_STEP;
    check("post_pc", o_pc, m_pc);
    check("post_status", o_status, m_flags);
    check("post_no_exec", o_exec, 0);
    if (!m_running) check("park_idle", o_mem_req, 0);
    $display("instr j=%0d c=%0d tgt=%02h we=%0d st=%03b waits=%0d -> taken=%0d pc=%02h flags=%03b",
             is_jump, cond, target, we, st, waits, taken, o_pc, o_status);
  endtask

  initial begin
    i_reset = 1'b0;
    i_run = 1'b0;
    i_step = 1'b0;
    i_mem_ready = 1'b0;
    clear_exec_inputs();
    @(negedge clk);
    do_reset();
    check("rst_pc", o_pc, 0);
    check("rst_status", o_status, 0);
    check("rst_req", o_mem_req, 0);
    check("rst_exec", o_exec, 0);
    check("rst_taken", o_jump_taken, 0);
    check("rst_halted", o_halted, 0);
    @(negedge clk);
    check("idle_stays", o_mem_req, 0);

    // Sequential run 0,1,2,3 then to 5 and a 3-cycle memory wait at 5
    for (int n = 0; n < 5; n++) exec_instr(0, 0, 2'b00, 8'h00, 0, 3'b000, 1);
    exec_instr(3, 0, 2'b00, 8'h00, 0, 3'b000, 1);

    // Conditional jumps with N set
    exec_instr(0, 0, 2'b00, 8'h00, 1, 3'b010, 1);
    exec_instr(0, 1, 2'b10, 8'h40, 0, 3'b000, 1);
    exec_instr(0, 1, 2'b01, 8'h40, 0, 3'b000, 1);
    exec_instr(0, 1, 2'b11, 8'h40, 0, 3'b000, 1);
    exec_instr(0, 1, 2'b00, 8'h40, 0, 3'b000, 1);

    // Flag hazard: GTIFZ uses old Z=0 while Z=1 is written
    exec_instr(0, 0, 2'b00, 8'h00, 1, 3'b000, 1);
    exec_instr(0, 1, 2'b01, 8'h20, 1, 3'b001, 1);
    // PC wrap
    exec_instr(1, 1, 2'b00, 8'hFF, 0, 3'b000, 1);
    exec_instr(0, 0, 2'b00, 8'h00, 0, 3'b000, 0);

    for (int n = 0; n < 40; n++)
      exec_instr($urandom_range(0, 3), 1'($urandom), 2'($urandom), 8'($urandom),
                 1'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0));

    // Halt with a jump also asserted; flags still written
    launch_if_idle();
    i_mem_ready = 1'b1;
    @(negedge clk);
    i_mem_ready = 1'b0;
    check("halt_exec", o_exec, 1);
    i_halt = 1'b1; i_is_jump = 1'b1; i_jump_cond = 2'b00; i_jump_target = 8'h33;
    i_status_we = 1'b1; i_status = 3'b110; i_run = 1'b1;
    @(negedge clk);
    clear_exec_inputs();
    m_flags = 3'b110;
    check("halted", o_halted, 1);
    check("halt_pc", o_pc, m_pc);
    check("halt_status", o_status, m_flags);
    for (int n = 0; n < 5; n++) begin
      check("halt_no_req", o_mem_req, 0);
      check("halt_hold", o_halted, 1);
      @(negedge clk);
    end
    check("halt_pc_frozen", o_pc, m_pc);
    $display("halt pc=%02h flags=%03b halted=%0d", o_pc, o_status, o_halted);

    do_reset();
    check("unhalt", o_halted, 0);
    check("unhalt_pc", o_pc, 0);
    check("unhalt_status", o_status, 0);

    // Reset during a fetch stall
    exec_instr(0, 1, 2'b00, 8'h77, 1, 3'b101, 1);
    launch_if_idle();
    i_mem_ready = 1'b0;
    check("stall_req", o_mem_req, 1);
    check("stall_pc", o_pc, 8'h77);
    @(negedge clk);
    i_reset = 1'b1;
    #1;
    check("req_during_rst", o_mem_req, 1);
    @(negedge clk);
    i_reset = 1'b0;
    i_run = 1'b0;
    check("rst_fetch_req", o_mem_req, 0);
    check("rst_fetch_pc", o_pc, 0);
    check("rst_fetch_status", o_status, 0);
    check("rst_fetch_exec", o_exec, 0);
    $display("reset mid-fetch pc=%02h req=%0d status=%03b", o_pc, o_mem_req, o_status);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
